stack_calculator: RTL and testbench
===================================

STACK_CALCULATOR -- requirements
Module: stack_calculator

Interface
REQ-001 Parameter WIDTH, default 8, SHALL be the operand/result data width (>=4).
REQ-002 Parameter DEPTH, default 4, SHALL be the operand stack depth in entries (>=2).
REQ-003 clk_100MHz  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 op_valid  input  1  SHALL flag an operation request.
REQ-006 op_ready  output  1  SHALL be high when a request can be accepted; transfer occurs when op_valid && op_ready.
REQ-007 op_code  input  3  SHALL select: 0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 MUL, 6 AND, 7 CLEAR.
REQ-008 operand  input  WIDTH  SHALL be the PUSH value, sampled only on transfer.
REQ-009 result  output  WIDTH  SHALL show the top-of-stack entry, 0 when the stack is empty.
REQ-010 result_valid  output  1  SHALL pulse for one cycle after every completed operation, including rejected ones.
REQ-011 depth_count  output  $clog2(DEPTH+1)  SHALL give the number of stacked entries.
REQ-012 err_code  output  2  SHALL report the last operation's status: 0 OK, 1 STACK_OVF, 2 STACK_UNF, 3 ARITH_OVF.

Function
REQ-013 The FSM SHALL have states IDLE and MUL_BUSY; op_ready SHALL be 1 in IDLE and 0 in MUL_BUSY.
REQ-014 Single-cycle ops (all except MUL) SHALL update the stack at the transfer edge, with result_valid and err_code updated on that same edge.
REQ-015 PUSH SHALL write operand on top; if depth_count==DEPTH it SHALL leave the stack unchanged and set err_code=1.
REQ-016 POP SHALL discard the top; with depth_count==0 it SHALL leave the stack unchanged and set err_code=2.
REQ-017 Binary ops SHALL take a=second entry, b=top, pop both and push f(a,b), reducing depth_count by 1; with depth_count<2 they SHALL leave the stack unchanged and set err_code=2.
REQ-018 ADD SHALL write (a+b) mod 2^WIDTH; on unsigned carry-out it SHALL set err_code=3 and still write the wrapped value.
REQ-019 SUB SHALL write (a-b) mod 2^WIDTH; if a<b (borrow) it SHALL set err_code=3 and still write the wrapped value.
REQ-020 AND SHALL write a&b with err_code=0.
REQ-021 MUL SHALL enter MUL_BUSY for exactly WIDTH cycles (shift-add), then write the low WIDTH bits of a*b on the final MUL_BUSY edge and return to IDLE; a nonzero high half SHALL set err_code=3.
REQ-022 During MUL_BUSY the stack, result and depth_count SHALL hold their pre-MUL values; op_valid SHALL be ignored.
REQ-023 CLEAR SHALL empty the stack (depth_count=0, result=0) with err_code=0, in one cycle.
REQ-024 NOP SHALL change nothing but SHALL pulse result_valid with err_code=0.
REQ-025 err_code SHALL hold until the next completed operation.
REQ-026 A MUL underflow (depth<2) SHALL be rejected in the transfer cycle without entering MUL_BUSY.

Reset
REQ-027 On rst_n low, the block SHALL immediately set: state IDLE, depth_count=0, result=0, result_valid=0, err_code=0, op_ready=1 after release; stack storage contents SHALL be don't-care.
REQ-028 Reset asserted during MUL_BUSY SHALL abort the multiply with no stack write.

Structure
REQ-029 Opcode constants, err_code constants and FSM state encoding SHALL reside in a shared package calc_pkg.
REQ-030 The multiply SHALL be a sub-module seq_multiplier (start, a, b -> done, product[2*WIDTH-1:0]), parametrised by WIDTH.
REQ-031 Stack storage SHALL be a register array with a top pointer; no RAM primitives.

Verification (WIDTH=8, DEPTH=4)
REQ-032 PUSH 5, PUSH 3, SUB -> result=2, depth_count=1, err_code=0; then PUSH 7, SUB -> result=0xFB, err_code=3.
REQ-033 PUSH 200, PUSH 100, ADD -> result=44, err_code=3; PUSH 12, PUSH 10, MUL -> op_ready low exactly 8 cycles, then result=120, depth_count=2, err_code=0.
REQ-034 PUSH 1,2,3,4 then PUSH 9 -> depth_count=4, result=4, err_code=1; CLEAR -> depth_count=0, result=0.
REQ-035 From empty: POP -> err_code=2; PUSH 6, ADD -> err_code=2, result=6, depth_count=1; MUL with one entry -> op_ready never drops.
REQ-036 PUSH 16, PUSH 32, MUL, assert rst_n low at cycle 4 of MUL_BUSY -> depth_count=0, result=0, op_ready=1 after release, no result_valid pulse.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcodes, status codes and FSM encoding for the stack calculator.
package calc_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned ERR_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_MUL   = 3'd5,
    OP_AND   = 3'd6,
    OP_CLEAR = 3'd7
  } op_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_OK        = 2'd0,
    ERR_STACK_OVF = 2'd1,
    ERR_STACK_UNF = 2'd2,
    ERR_ARITH_OVF = 2'd3
  } err_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/stack_calculator_if.sv
// Operation request / result bus of the stack calculator.
interface stack_calculator_if
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic              op_valid;
  logic              op_ready;
  logic [OP_W-1:0]   op_code;
  logic [WIDTH-1:0]  operand;
  logic [WIDTH-1:0]  result;
  logic              result_valid;
  logic [CW-1:0]     depth_count;
  logic [ERR_W-1:0]  err_code;

  modport master (
    output op_valid, op_code, operand,
    input  op_ready, result, result_valid, depth_count, err_code
  );

  modport slave (
    input  op_valid, op_code, operand,
    output op_ready, result, result_valid, depth_count, err_code
  );

endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_100MHz,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = $clog2(WIDTH);

  logic             busy_q;
  logic [SW-1:0]    step_q;
  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    acc_nxt;
  logic [WIDTH-1:0] mplier_q;

  // done/product describe the step in flight so the caller can commit on the last busy edge
  assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done    = busy_q && (step_q == SW'(WIDTH - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      step_q   <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      step_q   <= '0;
      mcand_q  <= PW'(a);
      acc_q    <= '0;
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= acc_nxt;
      mcand_q  <= {mcand_q[PW-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      step_q   <= step_q + SW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/stack_calculator.sv
// Register-array operand stack with single-cycle ALU ops and a multi-cycle multiply.
module stack_calculator
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk_100MHz,
  input logic               rst_n,
  stack_calculator_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rv_q, rv_d;
  err_e             err_q, err_d;
  logic             ready_q, ready_d;

  logic             wr_en;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  logic [IW-1:0]    top_idx, sec_idx;
  logic [WIDTH-1:0] a, b;
  logic             full, empty, has_two;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu;
  logic             alu_ovf;

  logic             mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  // Operands: a is the entry under the top, b is the top
  assign top_idx = IW'(cnt_q - CW'(1));
  assign sec_idx = IW'(cnt_q - CW'(2));
  assign a       = stack_q[sec_idx];
  assign b       = stack_q[top_idx];
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign has_two = (cnt_q >= CW'(2));

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    alu     = sum[WIDTH-1:0];
    alu_ovf = sum[WIDTH];
    case (op_e'(bus.op_code))
      OP_SUB: begin
        alu     = a - b;
        alu_ovf = (a < b);
      end
      OP_AND: begin
        alu     = a & b;
        alu_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .start      (mul_start),
    .a          (a),
    .b          (b),
    .done       (mul_done),
    .product    (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    rv_d      = 1'b0;
    err_d     = err_q;
    wr_en     = 1'b0;
    wr_idx    = sec_idx;
    wr_data   = alu;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.op_valid && ready_q) begin
          rv_d  = 1'b1;
          err_d = ERR_OK;
          case (op_e'(bus.op_code))
            OP_NOP: ;
            OP_PUSH: begin
              if (full) begin
                err_d = ERR_STACK_OVF;
              end else begin
                wr_en    = 1'b1;
                wr_idx   = IW'(cnt_q);
                wr_data  = bus.operand;
                cnt_d    = cnt_q + CW'(1);
                result_d = bus.operand;
              end
            end
            OP_POP: begin
              if (empty) begin
                err_d = ERR_STACK_UNF;
              end else begin
                cnt_d    = cnt_q - CW'(1);
                result_d = has_two ? a : '0;
              end
            end
            OP_ADD, OP_SUB, OP_AND: begin
              if (!has_two) begin
                err_d = ERR_STACK_UNF;
              end else begin
                wr_en    = 1'b1;
                cnt_d    = cnt_q - CW'(1);
                result_d = alu;
                err_d    = alu_ovf ? ERR_ARITH_OVF : ERR_OK;
              end
            end
            OP_MUL: begin
              if (!has_two) begin
                err_d = ERR_STACK_UNF;
              end else begin
                // completion (and its status) is reported when the multiply finishes
                rv_d      = 1'b0;
                err_d     = err_q;
                mul_start = 1'b1;
                state_d   = ST_MUL_BUSY;
                ready_d   = 1'b0;
              end
            end
            OP_CLEAR: begin
              cnt_d    = '0;
              result_d = '0;
            end
          endcase
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done) begin
          wr_en    = 1'b1;
          wr_data  = mul_product[WIDTH-1:0];
          cnt_d    = cnt_q - CW'(1);
          result_d = mul_product[WIDTH-1:0];
          err_d    = (|mul_product[2*WIDTH-1:WIDTH]) ? ERR_ARITH_OVF : ERR_OK;
          rv_d     = 1'b1;
          state_d  = ST_IDLE;
          ready_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      cnt_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
    end
  end

  // Storage contents are don't-care after reset; only the pointer is cleared
  always_ff @(posedge clk_100MHz) begin
    if (wr_en) begin
      stack_q[wr_idx] <= wr_data;
    end
  end

  assign bus.op_ready     = ready_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.depth_count  = cnt_q;
  assign bus.err_code     = err_q;

endmodule

// File: tb/tb_stack_calculator.sv
// Scenario bench for stack_calculator with a queue-based reference model and scoreboard.
module tb_stack_calculator;
  import calc_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    depth;
    logic [1:0]       err;
  } exp_t;

  logic clk_100MHz = 1'b0;
  logic rst_n      = 1'b1;
  int   total      = 0;
  int   bad        = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [WIDTH-1:0] mstk[$];

  stack_calculator_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stack_calculator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // Reference model: updates the model stack and returns the expected completion
  function automatic exp_t model_op(input logic [2:0] code, input logic [WIDTH-1:0] val);
    exp_t e;
    int unsigned x, y, r;
    e.err = 2'd0;
    case (code)
      OP_PUSH: if (mstk.size() == int'(DEPTH)) e.err = 2'd1; else mstk.push_back(val);
      OP_POP:  if (mstk.size() == 0) e.err = 2'd2; else mstk.delete(mstk.size() - 1);
      OP_ADD, OP_SUB, OP_MUL, OP_AND: begin
        if (mstk.size() < 2) begin
          e.err = 2'd2;
        end else begin
          y = mstk.pop_back();
          x = mstk.pop_back();
          case (code)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_MUL:  r = x * y;
            default: r = x & y;
          endcase
          if (code == OP_SUB) begin
            if (x < y) e.err = 2'd3;
          end else if ((r >> WIDTH) != 0) begin
            e.err = 2'd3;
          end
          mstk.push_back(WIDTH'(r));
        end
      end
      OP_CLEAR: mstk.delete();
      default: ;
    endcase
    e.result = (mstk.size() != 0) ? mstk[mstk.size() - 1] : '0;
    e.depth  = CW'(mstk.size());
    return e;
  endfunction

  // Scoreboard: every result_valid pulse consumes one expected completion
  always @(posedge clk_100MHz) begin
    #1;
    if (bus.result_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_pulse: result_valid=1 but required no completion at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.result !== mon_e.result) begin
          bad++;
          $display("FAIL sb_result: got %0d required %0d at %0t", bus.result, mon_e.result, $time);
        end
        total++;
        if (bus.depth_count !== mon_e.depth) begin
          bad++;
          $display("FAIL sb_depth: got %0d required %0d at %0t", bus.depth_count, mon_e.depth, $time);
        end
        total++;
        if (bus.err_code !== mon_e.err) begin
          bad++;
          $display("FAIL sb_err: got %0d required %0d at %0t", bus.err_code, mon_e.err, $time);
        end
      end
    end
  end

  // Issue one op and wait (bounded) for its completion; reports busy length and any output movement
  task automatic do_op(input logic [2:0] code, input logic [WIDTH-1:0] val, input bit poke,
                       output int low_cycles, output bit moved);
    logic [WIDTH-1:0] pre_res;
    logic [CW-1:0]    pre_dep;
    int n;
    @(negedge clk_100MHz);
    pre_res      = bus.result;
    pre_dep      = bus.depth_count;
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.operand  = val;
    exp_q.push_back(model_op(code, val));
    @(posedge clk_100MHz);
    #1;
    if (poke) begin
      bus.op_code = OP_PUSH;
      bus.operand = 8'h5A;
    end else begin
      bus.op_valid = 1'b0;
    end
    low_cycles = 0;
    moved      = 1'b0;
    n          = 0;
    while (bus.result_valid !== 1'b1 && n < 40) begin
      if (bus.op_ready !== 1'b1) low_cycles++;
      if (bus.result !== pre_res || bus.depth_count !== pre_dep) moved = 1'b1;
      @(posedge clk_100MHz);
      #1;
      n++;
    end
    bus.op_valid = 1'b0;
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL op_timeout: code=%0d got no result_valid, required one within 40 cycles", code);
    end
  endtask

  task automatic op(input logic [2:0] code, input logic [WIDTH-1:0] val);
    int l;
    bit m;
    do_op(code, val, 1'b0, l, m);
  endtask

  task automatic test_reset();
    bus.op_valid = 1'b0;
    bus.op_code  = OP_NOP;
    bus.operand  = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk_100MHz);
    #1;
    total++; if (bus.depth_count !== '0) begin bad++; $display("FAIL reset_depth: got %0d required 0", bus.depth_count); end
    total++; if (bus.result !== '0) begin bad++; $display("FAIL reset_result: got %0d required 0", bus.result); end
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv: got %0b required 0", bus.result_valid); end
    total++; if (bus.err_code !== 2'd0) begin bad++; $display("FAIL reset_err: got %0d required 0", bus.err_code); end
    @(negedge clk_100MHz);
    rst_n = 1'b1;
    @(posedge clk_100MHz);
    #1;
    total++; if (bus.op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b required 1", bus.op_ready); end
  endtask

  task automatic test_sub();
    op(OP_PUSH, 8'd5);
    op(OP_PUSH, 8'd3);
    op(OP_SUB, 8'd0);
    total++; if (bus.result !== 8'd2) begin bad++; $display("FAIL sub_result: got %0d required 2", bus.result); end
    total++; if (bus.depth_count !== 3'd1) begin bad++; $display("FAIL sub_depth: got %0d required 1", bus.depth_count); end
    total++; if (bus.err_code !== 2'd0) begin bad++; $display("FAIL sub_err: got %0d required 0", bus.err_code); end
    op(OP_PUSH, 8'd7);
    op(OP_SUB, 8'd0);
    total++; if (bus.result !== 8'hFB) begin bad++; $display("FAIL sub_borrow_result: got %0h required fb", bus.result); end
    total++; if (bus.err_code !== 2'd3) begin bad++; $display("FAIL sub_borrow_err: got %0d required 3", bus.err_code); end
    op(OP_CLEAR, 8'd0);
  endtask

  task automatic test_add_mul();
    int  low;
    bit  moved;
    op(OP_PUSH, 8'd200);
    op(OP_PUSH, 8'd100);
    op(OP_ADD, 8'd0);
    total++; if (bus.result !== 8'd44) begin bad++; $display("FAIL add_carry_result: got %0d required 44", bus.result); end
    total++; if (bus.err_code !== 2'd3) begin bad++; $display("FAIL add_carry_err: got %0d required 3", bus.err_code); end
    op(OP_PUSH, 8'd12);
    op(OP_PUSH, 8'd10);
    do_op(OP_MUL, 8'd0, 1'b1, low, moved);
    total++; if (low != 8) begin bad++; $display("FAIL mul_busy_len: got %0d cycles required 8", low); end
    total++; if (moved !== 1'b0) begin bad++; $display("FAIL mul_hold: got outputs changing required held during busy"); end
    total++; if (bus.result !== 8'd120) begin bad++; $display("FAIL mul_result: got %0d required 120", bus.result); end
    total++; if (bus.depth_count !== 3'd2) begin bad++; $display("FAIL mul_depth: got %0d required 2", bus.depth_count); end
    total++; if (bus.err_code !== 2'd0) begin bad++; $display("FAIL mul_err: got %0d required 0", bus.err_code); end
    op(OP_PUSH, 8'd20);
    op(OP_MUL, 8'd0);
    total++; if (bus.result !== 8'd96) begin bad++; $display("FAIL mul_ovf_result: got %0d required 96", bus.result); end
    total++; if (bus.err_code !== 2'd3) begin bad++; $display("FAIL mul_ovf_err: got %0d required 3", bus.err_code); end
    op(OP_CLEAR, 8'd0);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) op(OP_PUSH, 8'(i));
    op(OP_PUSH, 8'd9);
    total++; if (bus.depth_count !== 3'd4) begin bad++; $display("FAIL ovf_depth: got %0d required 4", bus.depth_count); end
    total++; if (bus.result !== 8'd4) begin bad++; $display("FAIL ovf_result: got %0d required 4", bus.result); end
    total++; if (bus.err_code !== 2'd1) begin bad++; $display("FAIL ovf_err: got %0d required 1", bus.err_code); end
    op(OP_CLEAR, 8'd0);
    total++; if (bus.depth_count !== 3'd0) begin bad++; $display("FAIL clear_depth: got %0d required 0", bus.depth_count); end
    total++; if (bus.result !== 8'd0) begin bad++; $display("FAIL clear_result: got %0d required 0", bus.result); end
  endtask

  task automatic test_underflow();
    int low;
    bit moved;
    op(OP_POP, 8'd0);
    total++; if (bus.err_code !== 2'd2) begin bad++; $display("FAIL pop_unf_err: got %0d required 2", bus.err_code); end
    @(posedge clk_100MHz);
    #1;
    total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL rv_pulse_width: got %0b required 0", bus.result_valid); end
    total++; if (bus.err_code !== 2'd2) begin bad++; $display("FAIL err_hold: got %0d required 2", bus.err_code); end
    op(OP_PUSH, 8'd6);
    op(OP_ADD, 8'd0);
    total++; if (bus.err_code !== 2'd2) begin bad++; $display("FAIL add_unf_err: got %0d required 2", bus.err_code); end
    total++; if (bus.result !== 8'd6) begin bad++; $display("FAIL add_unf_result: got %0d required 6", bus.result); end
    total++; if (bus.depth_count !== 3'd1) begin bad++; $display("FAIL add_unf_depth: got %0d required 1", bus.depth_count); end
    do_op(OP_MUL, 8'd0, 1'b0, low, moved);
    total++; if (low != 0) begin bad++; $display("FAIL mul_unf_ready: got %0d low cycles required 0", low); end
    op(OP_NOP, 8'd0);
    total++; if (bus.err_code !== 2'd0) begin bad++; $display("FAIL nop_err: got %0d required 0", bus.err_code); end
    op(OP_CLEAR, 8'd0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] code;
    for (int i = 0; i < 60; i++) begin
      code = 3'($urandom_range(0, 7));
      if (code == OP_CLEAR && $urandom_range(0, 3) != 0) code = OP_PUSH;
      op(code, 8'($urandom_range(0, 255)));
    end
    total++; if (bus.depth_count !== CW'(mstk.size())) begin bad++; $display("FAIL b2b_depth: got %0d required %0d", bus.depth_count, mstk.size()); end
    op(OP_CLEAR, 8'd0);
  endtask

  task automatic test_reset_mul();
    bit pulsed;
    op(OP_PUSH, 8'd16);
    op(OP_PUSH, 8'd32);
    @(negedge clk_100MHz);
    bus.op_valid = 1'b1;
    bus.op_code  = OP_MUL;
    @(posedge clk_100MHz);
    #1;
    bus.op_valid = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    #2 rst_n = 1'b0;
    mstk.delete();
    #1;
    total++; if (bus.depth_count !== 3'd0) begin bad++; $display("FAIL rstmul_depth: got %0d required 0", bus.depth_count); end
    total++; if (bus.result !== 8'd0) begin bad++; $display("FAIL rstmul_result: got %0d required 0", bus.result); end
    @(negedge clk_100MHz);
    rst_n  = 1'b1;
    pulsed = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_100MHz);
      #1;
      if (bus.result_valid === 1'b1) pulsed = 1'b1;
    end
    total++; if (pulsed !== 1'b0) begin bad++; $display("FAIL rstmul_pulse: got result_valid pulse required none"); end
    total++; if (bus.op_ready !== 1'b1) begin bad++; $display("FAIL rstmul_ready: got %0b required 1", bus.op_ready); end
    total++; if (bus.depth_count !== 3'd0) begin bad++; $display("FAIL rstmul_depth_after: got %0d required 0", bus.depth_count); end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_add_mul();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_reset_mul();
    repeat (2) @(posedge clk_100MHz);
    #2;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
